mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 8 +
 rtl/mem_responder_mem_array.sv | 18 +
 rtl/mem_responder.sv | 82 ++++++++
 tb/tb_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and sizing constants for the memory responder
package mem_responder_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int WAIT_CYCLES_DEF = 1;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port word storage with synchronous write and synchronous read
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave on a shared tristate bus with request handshake and error reporting
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] BUS,
  input  logic              Memread,
  input  logic              Memwrite,
  input  logic [31:0]       Addr,
  output logic              Ready,
  output logic              Err
);
  logic [1:0] rst_sync;
  logic rst_n_s;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd_q, mem_q;
  logic op_wr, oor, we, drive;
  logic [ADDR_W-1:0] idx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_s = rst_sync[1];
  assign oor = (addr_q >> (ADDR_W + 2)) != 32'd0;
  assign idx = state == IDLE ? Addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign we = state == RESP && op_wr && !oor;
  assign drive = (state == RESP || state == HOLD) && !op_wr && Memread && !Memwrite;
  assign BUS = drive ? rd_q : 'z;
  mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(we),
    .addr(idx),
    .wdata(wdata_q),
    .rdata(mem_q)
  );
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      op_wr <= 1'b0;
      rd_q <= '0;
      Ready <= 1'b0;
      Err <= 1'b0;
    end else begin
      Ready <= state == RESP;
      Err <= (state == IDLE && Memread && Memwrite) || (state == RESP && oor);
      case (state)
        IDLE: begin
          if (Memread && Memwrite) begin
            op_wr <= 1'b1;
            state <= HOLD;
          end else if (Memread || Memwrite) begin
            addr_q <= Addr;
            op_wr <= Memwrite;
            if (Memwrite) wdata_q <= BUS;
            cnt <= CNT_W'(WAIT_CYCLES);
            state <= WAIT_CYCLES == 0 ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (op_wr ? !Memwrite : !Memread) state <= IDLE;
          else if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (!op_wr) rd_q <= oor ? '0 : mem_q;
          state <= HOLD;
        end
        HOLD: if (!Memread && !Memwrite) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench over three wait-state configurations against a word-array model
module tb_mem_responder;
  localparam int WC [3] = '{0, 1, 3};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mr [3], mw [3], oe [3];
  logic [31:0] ad [3], wd [3];
  wire rdy [3], er [3];
  wire [31:0] bv [3];
  logic [31:0] model [3][256];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    wire [31:0] bus;
    assign bus = oe[g] ? wd[g] : 'z;
    assign bv[g] = bus;
    for (genvar b = 0; b < 32; b++) begin : p
      pullup (bus[b]);
    end
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WC[g])) dut (
      .clk(clk),
      .rst(rst),
      .BUS(bus),
      .Memread(mr[g]),
      .Memwrite(mw[g]),
      .Addr(ad[g]),
      .Ready(rdy[g]),
      .Err(er[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic access(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit oor = (a >> 10) != 0;
    logic [31:0] exp = oor ? 32'h0 : model[k][a[9:2]];
    @(negedge clk);
    ad[k] = a;
    mr[k] = !wr;
    mw[k] = wr;
    oe[k] = wr;
    wd[k] = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rdy[k] && n < 40);
    check($sformatf("latency[%0d]", k), n, WC[k] + 2);
    check($sformatf("err[%0d]", k), {31'b0, er[k]}, {31'b0, oor});
    if (!wr) check($sformatf("rdata[%0d] a=%h", k, a), bv[k], exp);
    else if (!oor) model[k][a[9:2]] = d;
    @(posedge clk);
    #1;
    check($sformatf("pulse[%0d]", k), {30'b0, rdy[k], er[k]}, 32'h0);
    if (!wr) check($sformatf("hold[%0d]", k), bv[k], exp);
    @(negedge clk);
    mr[k] = 1'b0;
    mw[k] = 1'b0;
    oe[k] = 1'b0;
    #1;
    check($sformatf("release_z[%0d]", k), bv[k], 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
  endtask
  initial begin
    int pool [6];
    int n;
    int hits;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      mr[k] = 1'b0;
      mw[k] = 1'b0;
      oe[k] = 1'b0;
      ad[k] = '0;
      wd[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready[%0d]", k), {31'b0, rdy[k]}, 32'h0);
      check($sformatf("rst_err[%0d]", k), {31'b0, er[k]}, 32'h0);
      check($sformatf("rst_bus[%0d]", k), bv[k], 32'hFFFFFFFF);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    access(1, 1'b1, 32'h10, 32'h202100E9);
    access(1, 1'b0, 32'h10, 32'h0);
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    ad[1] = 32'h10;
    mr[1] = 1'b1;
    mw[1] = 1'b1;
    @(posedge clk);
    #1;
    check("both_err", {30'b0, rdy[1], er[1]}, 32'h1);
    check("both_z", bv[1], 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("both_after", {30'b0, rdy[1], er[1]}, 32'h0);
    @(negedge clk);
    mr[1] = 1'b0;
    mw[1] = 1'b0;
    repeat (2) @(posedge clk);
    access(1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b0, 32'h400, 32'h0);
    access(1, 1'b1, 32'h410, 32'h12345678);
    access(1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 32'h3FC, 32'hA5A55A5A);
    access(1, 1'b0, 32'h3FF, 32'h0);
    access(2, 1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    ad[2] = 32'h20;
    wd[2] = 32'h11111111;
    mw[2] = 1'b1;
    oe[2] = 1'b1;
    @(negedge clk);
    mw[2] = 1'b0;
    oe[2] = 1'b0;
    hits = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      hits += int'(rdy[2] | er[2]);
    end
    check("abort_pulses", hits, 0);
    access(2, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    ad[1] = 32'h10;
    mr[1] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rdy[1] && n < 40);
    check("pre_rst_bus", bv[1], model[1][4]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hold_z", bv[1], 32'hFFFFFFFF);
    check("rst_hold_ready", {31'b0, rdy[1]}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rdy[1] && n < 40);
    check("post_rst_latency", n, WC[1] + 4);
    check("post_rst_data", bv[1], model[1][4]);
    @(negedge clk);
    mr[1] = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        pool[i] = $urandom_range(0, 255);
        access(k, 1'b1, 32'(pool[i]) << 2, $urandom);
      end
      for (int i = 0; i < 20; i++) begin
        a = (32'(pool[$urandom_range(0, 5)]) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a |= 32'($urandom_range(1, 1023)) << 10;
        access(k, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
